// File: rtl/mult_seq_hs_pkg.sv
// ---------------------------------------------------------------------------
// mult_seq_hs_pkg
//
// Shared definitions for the sequential shift-add multiplier.
//   state_t       : 2-bit FSM encoding (IDLE, CALC, SIGN, DONE)
//   calc_latency  : clock edges from operand accept to out_valid rising,
//                   given the multiplier width b_w (b_w iterations plus the
//                   sign-fixup cycle)
// ---------------------------------------------------------------------------
package mult_seq_hs_pkg;

    // Controller states. IDLE waits for operands, CALC runs one shift-add
    // iteration per cycle, SIGN applies the deferred sign, and DONE holds
    // the product until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    // One cycle per multiplier bit, plus the SIGN cycle.
    function automatic int calc_latency(input int b_w);
        return b_w + 1;
    endfunction

endpackage : mult_seq_hs_pkg

// File: rtl/mult_seq_hs_abs.sv
// ---------------------------------------------------------------------------
// mult_abs
//
// Conditional two's-complement magnitude. When is_signed is set and the
// input is negative, the output is the negated value; otherwise the input
// passes through unchanged. The result is an unsigned W-bit magnitude, so
// the most-negative input -2^(W-1) maps exactly onto 2^(W-1).
//
// Ports
//   val       input  [W-1:0]  operand bit pattern
//   is_signed input           1: treat val as two's complement
//   mag       output [W-1:0]  unsigned magnitude (combinational)
// ---------------------------------------------------------------------------
module mult_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] val,
    input  logic         is_signed,
    output logic [W-1:0] mag
);

    logic is_neg;

    // Only a signed operand with its MSB set needs negating. Unary minus
    // at W bits wraps -2^(W-1) back onto its own pattern, which read as
    // unsigned is exactly the wanted magnitude.
    assign is_neg = is_signed & val[W-1];
    assign mag    = is_neg ? (-val) : val;

endmodule : mult_abs

// File: rtl/mult_seq_hs.sv
// ---------------------------------------------------------------------------
// mult_seq_hs
//
// Sequential shift-add multiplier with valid/ready handshakes on both sides.
// Signed operation is done on magnitudes; the sign is re-applied in a
// single SIGN cycle once all B_W iterations have finished.
//
// Ports
//   clk        input              sole clock, rising edge
//   rst        input              asynchronous reset, active low
//   in_valid   input              operand set offered
//   in_ready   output             operand set can be accepted this cycle
//   in_signed  input              1: two's-complement operands, 0: unsigned
//   in_a       input  [A_W-1:0]   multiplicand
//   in_b       input  [B_W-1:0]   multiplier
//   out_valid  output             product held on out_p
//   out_ready  input              downstream consumes the product
//   out_p      output [A_W+B_W-1:0] product, signedness of accepted operands
//
// Latency from the accept edge to out_valid rising is B_W+1 edges and does
// not depend on operand values.
// ---------------------------------------------------------------------------
module mult_seq_hs
    import mult_seq_hs_pkg::*;
#(
    parameter int A_W = 8,
    parameter int B_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [A_W-1:0]     in_a,
    input  logic [B_W-1:0]     in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] out_p
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(B_W) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [P_W-1:0]   a_sh;
    logic [B_W-1:0]   b_sh;
    logic [P_W-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic             neg;

    logic [A_W-1:0]   a_mag;
    logic [B_W-1:0]   b_mag;
    logic             accept;
    logic             in_neg;

    // Magnitudes of the incoming operands, used only on the accept edge.
    mult_abs #(.W(A_W)) u_abs_a (
        .val       (in_a),
        .is_signed (in_signed),
        .mag       (a_mag)
    );

    mult_abs #(.W(B_W)) u_abs_b (
        .val       (in_b),
        .is_signed (in_signed),
        .mag       (b_mag)
    );

    // A new operand set is taken when idle, or while the finished product
    // is being consumed in the same cycle, which lets back-to-back
    // operations run without an idle bubble.
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign in_neg   = in_signed & (in_a[A_W-1] ^ in_b[B_W-1]);

    // Controller and datapath. Taking new operands overrides everything
    // else; that is only possible from IDLE or DONE, so a running
    // computation can never be disturbed. In CALC the multiplicand moves
    // left and the multiplier right, so bit 0 of b_sh always selects
    // whether the current shifted multiplicand is added.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            out_p     <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            a_sh      <= {{B_W{1'b0}}, a_mag};
            b_sh      <= b_mag;
            acc       <= '0;
            cnt       <= '0;
            neg       <= in_neg;
            out_valid <= 1'b0;
            state     <= CALC;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end

                CALC: begin
                    if (b_sh[0]) begin
                        acc <= acc + a_sh;
                    end
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state <= SIGN;
                    end
                end

                SIGN: begin
                    out_p     <= neg ? (-acc) : acc;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : mult_seq_hs

// File: tb/tb_mult_seq_hs.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_hs
//
// Self-checking bench for mult_seq_hs at A_W=5, B_W=4. Directed vectors
// with hand-computed products, hand-written backpressure and mid-compute
// reset sequences, and a random stream compared against an integer
// multiply reference in arrival order.
// ---------------------------------------------------------------------------
module tb_mult_seq_hs;
    import mult_seq_hs_pkg::*;

    localparam int A_W = 5;
    localparam int B_W = 4;
    localparam int P_W = A_W + B_W;
    localparam int N_RANDOM = 60;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           in_signed;
    logic [A_W-1:0] in_a;
    logic [B_W-1:0] in_b;
    logic           out_valid;
    logic           out_ready;
    logic [P_W-1:0] out_p;

    int checks;
    int errors;

    typedef struct {
        logic           sgn;
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [P_W-1:0] p;
        string          name;
    } vec_t;

    vec_t vecs[12];

    mult_seq_hs #(.A_W(A_W), .B_W(B_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product using a plain integer multiply, truncated to P_W.
    function automatic logic [P_W-1:0] ref_mul(input logic s,
                                               input logic [A_W-1:0] a,
                                               input logic [B_W-1:0] b);
        int ia;
        int ib;
        int p;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        p  = ia * ib;
        return p[P_W-1:0];
    endfunction

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offers one operand set at a falling edge (with the given out_ready),
    // lets it be accepted on the next rising edge, then counts rising edges
    // until out_valid appears. Also reports whether in_ready was ever seen
    // high while the computation was running.
    task automatic applyStimulus(input logic s, input logic [A_W-1:0] a,
                                 input logic [B_W-1:0] b, input logic ordy,
                                 input string name,
                                 output int lat, output logic busy_ready);
        @(negedge clk);
        in_signed = s;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = ordy;
        #1;
        checkOutput({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_signed  = 1'b0;
        lat        = 0;
        busy_ready = 1'b0;
        checkOutput({name, " out_valid low after accept"}, 32'(out_valid), 32'd0);
        while (!out_valid && lat < 20) begin
            if (in_ready) busy_ready = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Consumes the held product with a one-cycle out_ready pulse.
    task automatic drain(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({name, " out_valid low after consume"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int   lat;
        logic busy_ready;
        logic [P_W-1:0] held;
        logic [P_W-1:0] exp_q[$];
        logic [P_W-1:0] exp_p;
        int   sent;
        int   received;
        int   cycles;
        logic hs_in;
        logic hs_out;
        logic [P_W-1:0] seen_p;

        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b1, 5'b10000, 4'b1000, 9'd128,  "signed min*min"};
        vecs[1]  = '{1'b0, 5'd31,    4'd15,   9'd465,  "unsigned max"};
        vecs[2]  = '{1'b1, 5'd31,    4'd15,   9'd1,    "signed -1*-1"};
        vecs[3]  = '{1'b1, 5'd7,     4'b1101, 9'h1EB,  "signed 7*-3"};
        vecs[4]  = '{1'b0, 5'd0,     4'd0,    9'd0,    "zero*zero"};
        vecs[5]  = '{1'b0, 5'd16,    4'd8,    9'd128,  "unsigned 16*8"};
        vecs[6]  = '{1'b1, 5'b10000, 4'd7,    9'h190,  "signed -16*7"};
        vecs[7]  = '{1'b1, 5'd15,    4'b1000, 9'h188,  "signed 15*-8"};
        vecs[8]  = '{1'b0, 5'd1,     4'd1,    9'd1,    "unsigned 1*1"};
        vecs[9]  = '{1'b1, 5'd0,     4'b1000, 9'd0,    "signed 0*-8"};
        vecs[10] = '{1'b1, 5'b11111, 4'd1,    9'h1FF,  "signed -1*1"};
        vecs[11] = '{1'b0, 5'd5,     4'd9,    9'd45,   "unsigned 5*9"};

        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        rst       = 1'b0;

        // Reset state
        #12;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_p", 32'(out_p), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Directed vector table
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0, vecs[i].name,
                          lat, busy_ready);
            checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(calc_latency(B_W)));
            checkOutput({vecs[i].name, " product"}, 32'(out_p), 32'(vecs[i].p));
            checkOutput({vecs[i].name, " in_ready while busy"}, 32'(busy_ready), 32'd0);
            drain(vecs[i].name);
        end

        // Backpressure: product and in_ready hold for 10 cycles of out_ready=0
        applyStimulus(1'b0, 5'd13, 4'd11, 1'b0, "backpressure", lat, busy_ready);
        checkOutput("backpressure product", 32'(out_p), 32'd143);
        held = out_p;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = (c % 2) == 1;
            in_a     = 5'd9;
            in_b     = 4'd9;
            #1;
            checkOutput("backpressure hold out_p", 32'(out_p), 32'(held));
            checkOutput("backpressure hold out_valid", 32'(out_valid), 32'd1);
            checkOutput("backpressure in_ready", 32'(in_ready), 32'd0);
        end
        // Consume and accept a new set on the same edge
        applyStimulus(1'b0, 5'd3, 4'd2, 1'b1, "consume+accept", lat, busy_ready);
        checkOutput("consume+accept latency", 32'(lat), 32'(calc_latency(B_W)));
        checkOutput("consume+accept product", 32'(out_p), 32'd6);
        drain("consume+accept");

        // Reset two cycles into CALC
        applyStimulus(1'b0, 5'd31, 4'd15, 1'b0, "pre-reset", lat, busy_ready);
        drain("pre-reset");
        @(negedge clk);
        in_signed = 1'b0;
        in_a      = 5'd31;
        in_b      = 4'd15;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid-calc reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid-calc reset out_p", 32'(out_p), 32'd0);
        checkOutput("mid-calc reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        applyStimulus(1'b0, 5'd3, 4'd5, 1'b0, "after reset", lat, busy_ready);
        checkOutput("after reset latency", 32'(lat), 32'(calc_latency(B_W)));
        checkOutput("after reset product", 32'(out_p), 32'd15);
        drain("after reset");

        // Random stream with random out_ready, checked in order
        sent     = 0;
        received = 0;
        cycles   = 0;
        hs_in    = 1'b0;
        while ((sent < N_RANDOM || received < sent) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (hs_in) in_valid = 1'b0;
            if (!in_valid && sent < N_RANDOM && ($urandom_range(0, 3) != 0)) begin
                in_signed = 1'($urandom_range(0, 1));
                in_a      = A_W'($urandom);
                in_b      = B_W'($urandom);
                in_valid  = 1'b1;
                exp_q.push_back(ref_mul(in_signed, in_a, in_b));
                sent++;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            hs_in  = in_valid & in_ready;
            hs_out = out_valid & out_ready;
            seen_p = out_p;
            @(posedge clk);
            if (hs_out) begin
                if (exp_q.size() == 0) begin
                    checkOutput("random unexpected product", 32'(seen_p), 32'hFFFF_FFFF);
                end else begin
                    exp_p = exp_q.pop_front();
                    checkOutput("random product", 32'(seen_p), 32'(exp_p));
                end
                received++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("random products received", 32'(received), 32'(N_RANDOM));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mult_seq_hs

// File: doc/mult_seq_hs.md
MULT_SEQ_HS -- requirements
Module: mult_seq_hs

Interface
REQ-001 Parameter A_W, default 8: operand A width, legal 2..32.
REQ-002 Parameter B_W, default 8: operand B width and iteration count, legal 2..32.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept an operand set this cycle.
REQ-007 in_signed  input  1  1: operands are two's complement; 0: unsigned; sampled on accept.
REQ-008 in_a  input  A_W  multiplicand.
REQ-009 in_b  input  B_W  multiplier.
REQ-010 out_valid  output  1  product held on out_p.
REQ-011 out_ready  input  1  downstream consumes product.
REQ-012 out_p  output  A_W+B_W  product, same signedness as the accepted operands.

Function
REQ-013 The block SHALL use states IDLE, CALC, SIGN and DONE; accept = in_valid & in_ready.
REQ-014 The block SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-015 On accept, the block SHALL register the magnitudes |in_a| and |in_b| when signed, or the raw values when unsigned, plus neg = in_signed & (in_a[MSB] ^ in_b[MSB]), clear the accumulator and the counter, and enter CALC.
REQ-016 Magnitudes SHALL be held unsigned at full operand width, so that the most-negative input (e.g. -2^(A_W-1)) is represented exactly.
REQ-017 In CALC, each cycle the block SHALL add the left-shifted A to the accumulator when the LSB of the right-shifted B is 1, then shift both; after exactly B_W iterations (counter == B_W-1) the block SHALL enter SIGN.
REQ-018 In SIGN, the block SHALL load out_p with the two's-complement negation of the accumulator if neg, else the accumulator; set out_valid; and enter DONE.
REQ-019 Latency: out_valid SHALL rise B_W+1 clock edges after the accept edge.
REQ-020 In DONE, out_p and out_valid SHALL hold stable until out_ready=1.
REQ-021 In DONE with out_ready=1: if in_valid=1, the block SHALL accept the new operands and enter CALC, with out_valid falling on the same edge; otherwise it SHALL enter IDLE.
REQ-022 in_valid during CALC or SIGN SHALL be ignored (in_ready=0); operands SHALL NOT change mid-computation.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 Zero operands SHALL still take the full latency.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, out_valid=0, out_p=0, accumulator, counter and neg all 0, and in_ready=1 after release, including when asserted mid-CALC; no partial result is emitted.
REQ-026 The first accept after reset release SHALL be allowed on the first rising edge with rst=1.

Structure
REQ-027 A shared package SHALL hold the state enumeration (2-bit encoding) and a latency constant function returning B_W+1.
REQ-028 One sub-module, mult_abs (conditional two's-complement magnitude, parameter W), SHALL be instantiated for each operand, with a combinational output.
REQ-029 The counter width SHALL be clog2(B_W)+1; the accumulator width SHALL be A_W+B_W.

Verification (A_W=5, B_W=4)
REQ-030 Signed corner: in_signed=1, a=5'b10000 (-16), b=4'b1000 (-8) -> out_p=9'd128 five edges after accept.
REQ-031 Unsigned maximum: in_signed=0, a=31, b=15 -> out_p=9'd465; the same bit patterns with in_signed=1 (-1*-1) -> 9'd1.
REQ-032 Mixed sign: a=7, b=-3 (4'b1101), signed -> out_p=9'h1EB (-21).
REQ-033 Backpressure: out_ready=0 for 10 cycles after out_valid -> out_p stable and in_ready=0 throughout; then out_ready=1 with in_valid=1 (a=3, b=2) -> new accept on that edge and out_p=6 five edges later.
REQ-034 Reset mid-CALC: assert rst two cycles after accept -> out_valid=0 and out_p=0 immediately; the next operand set yields a correct product with no stale contribution.
REQ-035 Random signed/unsigned streams with random out_ready SHALL be checked against a reference model, with every product seen exactly once and in order.
